// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

   localparam int DATA_BITS       = 8;
   localparam int DEFAULT_CLK_DIV = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of the serial line, control, FIFO read port and status of the receiver.
interface uart_rx_ctrl_if;
   import uart_pkg::*;

   // Read handshake: rdy is the valid for data; a byte leaves the FIFO on any
   // rising clk edge where rd and rdy are both high. rd with rdy low is ignored.
   logic                 x;
   logic                 en;
   logic                 rd;
   logic                 clr;
   logic                 rdy;
   logic [DATA_BITS-1:0] data;
   logic                 frame_err;
   logic                 overrun;
   uart_state_e          state;

   modport master (
      output x, en, rd, clr,
      input  rdy, data, frame_err, overrun, state
   );

   modport slave (
      input  x, en, rd, clr,
      output rdy, data, frame_err, overrun, state
   );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Receive FIFO: extra pointer MSB tells full from empty; a pop frees room for a same-cycle push.
module rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             pop_ok;
   logic             push_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM, sticky error flags and a receive FIFO.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_ctrl_if.slave  bus
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam int            BW        = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV/2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic                 sync1_q, xs_q, xs_prev_q;
   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 armed_q, armed_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 push, frame_set, cnt_zero;
   logic                 fifo_full, fifo_empty, pop_req, overrun_set;
   logic [DATA_BITS-1:0] fifo_data;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      armed_d   = armed_q | xs_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && xs_prev_q && !xs_q) begin
               state_d = START;
               cnt_d   = HALF_LOAD;
            end
         end
         START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!xs_q) begin
               state_d   = DATA;
               cnt_d     = FULL_LOAD;
               bit_idx_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               shift_d = {xs_q, shift_q[DATA_BITS-1:1]};
               cnt_d   = FULL_LOAD;
               if (bit_idx_q == LAST_BIT) state_d = STOP;
               else                       bit_idx_d = bit_idx_q + BW'(1);
            end
         end
         STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = IDLE;
               if (xs_q) begin
                  push = 1'b1;
               end else begin
                  frame_set = 1'b1;
                  armed_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Disabling abandons any frame in flight; nothing it produced is kept.
      if (!bus.en) begin
         state_d   = IDLE;
         cnt_d     = '0;
         bit_idx_d = '0;
         push      = 1'b0;
         frame_set = 1'b0;
      end
   end

   assign pop_req     = bus.rd && !fifo_empty;
   assign overrun_set = push && fifo_full && !pop_req;

   always_comb begin
      frame_err_d = frame_err_q | frame_set;
      overrun_d   = overrun_q | overrun_set;
      if (bus.clr) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         xs_q        <= 1'b1;
         xs_prev_q   <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b1;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= bus.x;
         xs_q        <= sync1_q;
         xs_prev_q   <= xs_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (shift_q),
      .pop_i   (bus.rd),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.rdy       = !fifo_empty;
   assign bus.data      = fifo_data;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.state     = state_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 868, SHALL be the number of clk cycles per serial bit; legal range is 4 or more.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL be the receive FIFO depth; it must be a power of 2 and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 x  input  1  SHALL be the asynchronous serial line (idle high, 8N1, LSB first).
REQ-006 en  input  1  SHALL be the receive enable; when low, reception is halted.
REQ-007 rd  input  1  SHALL pop the FIFO head when rd and rdy are both high in the same cycle.
REQ-008 rdy  output  1  SHALL be high while the FIFO is not empty.
REQ-009 data  output  8  SHALL present the FIFO head byte; it is valid only while rdy is high.
REQ-010 frame_err  output  1  SHALL be a sticky flag set on a bad stop bit.
REQ-011 overrun  output  1  SHALL be a sticky flag set when a byte is dropped because the FIFO is full.
REQ-012 clr  input  1  SHALL clear frame_err and overrun in the next cycle; clr has priority over a same-cycle set.

Function
REQ-013 x SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value xs.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 IDLE: on a falling edge of xs (previous 1, current 0) with en high, the FSM SHALL go to START and load the bit counter with CLK_DIV/2-1.
REQ-016 START: when the counter reaches 0, if xs=0 the FSM SHALL go to DATA (counter=CLK_DIV-1, bit index=0); otherwise it SHALL return to IDLE as a glitch, with no flag set.
REQ-017 DATA: at each counter expiry the FSM SHALL shift xs into the MSB of the shift register (LSB-first); after the 8th sample it SHALL go to STOP with counter=CLK_DIV-1.
REQ-018 STOP: at counter expiry, if xs=1 the byte SHALL be pushed; if xs=0, frame_err SHALL set and the byte SHALL be discarded; the FSM then goes to IDLE in both cases.
REQ-019 After a frame error, IDLE SHALL require xs=1 before it accepts a new falling edge, so a break condition is not re-triggered.
REQ-020 Push latency: the byte SHALL be visible on data with rdy high in the cycle after the stop-bit sample.
REQ-021 A push into a full FIFO SHALL drop the byte and set overrun; FIFO contents SHALL be unchanged.
REQ-022 Push and pop in the same cycle with the FIFO full SHALL succeed, with no overrun and occupancy unchanged.
REQ-023 Push and pop in the same cycle with the FIFO empty: the pop SHALL be ignored because rdy is low, and the push SHALL complete.
REQ-024 rd while rdy is low SHALL have no effect.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be decided by comparing the MSBs of the pointers.
REQ-026 Bit counter width SHALL be $clog2(CLK_DIV); it counts down only and never wraps through zero into an active sample.
REQ-027 en low SHALL force the FSM to IDLE in the next cycle and discard any partial byte; FIFO contents, flags and pop handling SHALL be unaffected.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL set: FSM=IDLE, counters=0, FIFO empty, rdy=0, data=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-029 Reset asserted mid-byte SHALL discard the byte; the first valid start bit after release SHALL be received correctly.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the default CLK_DIV.
REQ-031 The FIFO SHALL be a sub-module named rx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty interface); the FSM, synchronizer and flags SHALL live in uart_rx_ctrl.

Verification (CLK_DIV=16, FIFO_DEPTH=4)
REQ-032 Send 0xA5 (8N1) -> rdy rises in the cycle after the stop sample, data=0xA5, frame_err=0, overrun=0.
REQ-033 Drive x low for 4 clks, then high -> FSM returns to IDLE, rdy stays 0, no flags set.
REQ-034 Send 0x3C with a low stop bit -> frame_err=1, rdy=0; pulse clr -> frame_err=0; a following 0x11 frame -> data=0x11.
REQ-035 Send 0x01..0x05 with rd=0 -> overrun=1; then 4 pops return 0x01, 0x02, 0x03, 0x04, and rdy=0 afterwards.
REQ-036 FIFO full, rd=1 in the stop-sample push cycle -> overrun stays 0, 4 entries remain, and the new byte is last out.
REQ-037 Drop rst_n (or en) at bit 3 of 0x5A -> all outputs 0 (or FIFO intact for en); then send 0xC3 -> data=0xC3.
